// File: rtl/compare_arbiter_if.sv
// Request/response bundle for the shared branch comparator arbiter.
// master: requesters and result consumer; slave: the arbiter.
interface compare_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_funct3;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_funct3;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_flag;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_funct3,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_flag, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct3,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_flag, rsp_err
    );
endinterface

// File: rtl/compare_arbiter.sv
// Two-requester arbiter sharing one RV32 comparator with a one-entry result slot.
// COMPARE_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module compare_arbiter #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    compare_arbiter_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             can_accept;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_f3;
    logic             cmp_flag;
    logic             cmp_err;
    logic             flag_q;
    logic             id_q;
    logic             err_q;

`ifdef COMPARE_ARB_RR_EN
    logic last_grant;

    // On contention the requester that did not win last time goes first.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end
`else
    assign grant1 = bus.req1_valid && !bus.req0_valid;
`endif

    assign can_accept     = (state == EMPTY) || bus.rsp_ready;
    assign bus.req0_ready = can_accept && bus.req0_valid && !grant1;
    assign bus.req1_ready = can_accept && grant1;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign op_a  = grant1 ? bus.req1_a      : bus.req0_a;
    assign op_b  = grant1 ? bus.req1_b      : bus.req0_b;
    assign op_f3 = grant1 ? bus.req1_funct3 : bus.req0_funct3;

    always_comb begin
        cmp_flag = 1'b0;
        cmp_err  = 1'b0;
        case (op_f3)
            3'd0:    cmp_flag = (op_a == op_b);
            3'd1:    cmp_flag = (op_a != op_b);
            3'd4:    cmp_flag = ($signed(op_a) <  $signed(op_b));
            3'd5:    cmp_flag = ($signed(op_a) >= $signed(op_b));
            3'd6:    cmp_flag = (op_a <  op_b);
            3'd7:    cmp_flag = (op_a >= op_b);
            default: cmp_err  = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL: begin
                if (accept)
                    state_next = FULL;
                else if (bus.rsp_ready)
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
            id_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            flag_q <= cmp_flag;
            id_q   <= grant1;
            err_q  <= cmp_err;
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_flag  = flag_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter with a cycle-level reference model.
// Honours COMPARE_ARB_RR_EN to pick the expected arbitration policy.
module tb_compare_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    compare_arbiter_if #(.WIDTH(32)) bus();

    compare_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    bit m_valid, m_id, m_flag, m_err, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {err, flag} straight from the RV32 branch semantics.
    function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: return {1'b0, a == b};
            3'd1: return {1'b0, a != b};
            3'd4: return {1'b0, sa < sb};
            3'd5: return {1'b0, sa >= sb};
            3'd6: return {1'b0, a < b};
            3'd7: return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    function automatic int winner(input bit v0, input bit v1, input bit last);
        if (v0 && v1) begin
`ifdef COMPARE_ARB_RR_EN
            return last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        logic [1:0] r;
        if (reset) begin
            m_valid = 0; m_id = 0; m_flag = 0; m_err = 0; m_last = 1;
        end else begin
            w = winner(bus.req0_valid, bus.req1_valid, m_last);
            if ((!m_valid || bus.rsp_ready) && w >= 0) begin
                r = (w == 0) ? ref_cmp(bus.req0_a, bus.req0_b, bus.req0_funct3)
                             : ref_cmp(bus.req1_a, bus.req1_b, bus.req1_funct3);
                m_valid = 1;
                m_id    = (w == 1);
                m_flag  = r[0];
                m_err   = r[1];
                m_last  = (w == 1);
            end else if (m_valid && bus.rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        bit can;
        if (started) begin
            w   = winner(bus.req0_valid, bus.req1_valid, m_last);
            can = !m_valid || bus.rsp_ready;
            chk("model_req0_ready", bus.req0_ready, can && w == 0);
            chk("model_req1_ready", bus.req1_ready, can && w == 1);
            chk("model_rsp_valid", bus.rsp_valid, m_valid);
            if (m_valid) begin
                chk("model_rsp_id", bus.rsp_id, m_id);
                chk("model_rsp_flag", bus.rsp_flag, m_flag);
                chk("model_rsp_err", bus.rsp_err, m_err);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
    endtask

    initial begin
        bit hold0, hold1;
        reset = 1;
        idle_reqs();
        bus.req0_a = 0; bus.req0_b = 0; bus.req0_funct3 = 0;
        bus.req1_a = 0; bus.req1_b = 0; bus.req1_funct3 = 0;
        bus.rsp_ready = 1;
        cycle();
        started = 1;
        cycle();
        reset = 0;
        #2;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_flag", bus.rsp_flag, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        cycle();

        // single request
        bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 5; bus.req0_funct3 = 0;
        #2;
        chk("single_ready", bus.req0_ready, 1);
        cycle();
        bus.req0_valid = 0;
        #2;
        chk("single_valid", bus.rsp_valid, 1);
        chk("single_id", bus.rsp_id, 0);
        chk("single_flag", bus.rsp_flag, 1);
        chk("single_err", bus.rsp_err, 0);
        cycle();

        // signed vs unsigned
        bus.req1_valid = 1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 1; bus.req1_funct3 = 4;
        cycle();
        bus.req1_funct3 = 6;
        #2;
        chk("slt_flag", bus.rsp_flag, 1);
        chk("slt_id", bus.rsp_id, 1);
        cycle();
        bus.req1_valid = 0;
        #2;
        chk("sltu_flag", bus.rsp_flag, 0);
        chk("sltu_id", bus.rsp_id, 1);
        cycle();

        // contention
        bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 2; bus.req0_funct3 = 1;
        bus.req1_valid = 1; bus.req1_a = 3; bus.req1_b = 3; bus.req1_funct3 = 7;
        for (int k = 0; k < 6; k++) begin
            #2;
`ifdef COMPARE_ARB_RR_EN
            chk("rr_req0_ready", bus.req0_ready, (k % 2) == 0);
            chk("rr_req1_ready", bus.req1_ready, (k % 2) == 1);
`else
            chk("fix_req0_ready", bus.req0_ready, 1);
            chk("fix_req1_ready", bus.req1_ready, 0);
`endif
            cycle();
        end
        bus.req0_valid = 0;
        #2;
        chk("contend_req1_alone", bus.req1_ready, 1);
        cycle();
        idle_reqs();
        cycle();

        // backpressure
        bus.req0_valid = 1; bus.req0_a = 10; bus.req0_b = 5; bus.req0_funct3 = 5;
        cycle();
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_a = 3; bus.req1_b = 7; bus.req1_funct3 = 4;
        bus.rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_flag", bus.rsp_flag, 1);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_req1_ready", bus.req1_ready, 0);
            cycle();
        end
        bus.rsp_ready = 1;
        #2;
        chk("bp_release_ready", bus.req1_ready, 1);
        cycle();
        bus.req1_valid = 0;
        #2;
        chk("bp_next_valid", bus.rsp_valid, 1);
        chk("bp_next_id", bus.rsp_id, 1);
        chk("bp_next_flag", bus.rsp_flag, 1);
        cycle();

        // illegal op, then reset while full
        bus.req0_valid = 1; bus.req0_a = 0; bus.req0_b = 0; bus.req0_funct3 = 2;
        cycle();
        bus.req0_valid = 0;
        bus.rsp_ready = 0;
        #2;
        chk("illegal_flag", bus.rsp_flag, 0);
        chk("illegal_err", bus.rsp_err, 1);
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        bus.rsp_ready = 1;
        bus.req0_valid = 1; bus.req0_funct3 = 0;
        bus.req1_valid = 1;
        #2;
        chk("rst_full_valid", bus.rsp_valid, 0);
        chk("rst_first_req0", bus.req0_ready, 1);
        chk("rst_first_req1", bus.req1_ready, 0);
        cycle();
        idle_reqs();
        cycle();

        // mixed traffic obeying the hold-until-accepted rule
        hold0 = 0;
        hold1 = 0;
        for (int k = 0; k < 60; k++) begin
            if (!hold0) begin
                bus.req0_valid  = $urandom_range(0, 1);
                bus.req0_a      = $urandom_range(0, 3) - 1;
                bus.req0_b      = $urandom_range(0, 3) - 1;
                bus.req0_funct3 = $urandom_range(0, 7);
            end
            if (!hold1) begin
                bus.req1_valid  = $urandom_range(0, 1);
                bus.req1_a      = $urandom_range(0, 3) - 1;
                bus.req1_b      = $urandom_range(0, 3) - 1;
                bus.req1_funct3 = $urandom_range(0, 7);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #2;
            hold0 = bus.req0_valid && !bus.req0_ready;
            hold1 = bus.req1_valid && !bus.req1_ready;
            cycle();
        end
        idle_reqs();
        bus.rsp_ready = 1;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
